// File: rtl/etapa2_pkg.sv
// Shared geometry, FSM state type and tap record for the stage-2 convolution sequencer.
package etapa2_pkg;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned N_CH   = 3;
  localparam int unsigned N_FILT = 4;
  localparam int unsigned K      = 3;
  localparam int unsigned OUT_W  = IMG_W - K + 1;
  localparam int unsigned PLANE  = IMG_W * IMG_W;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StEmit,
    StDone
  } state_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [1:0] kr;
    logic [1:0] kc;
    logic [1:0] filt;
    logic       first;
    logic       last;
  } tap_t;

endpackage

// File: rtl/s2_window_counter.sv
// Nested tap counter (ch,kr,kc) and window counter (filt,row,col); both wrap to zero after
// their final step so the next window/pass starts clean.
module s2_window_counter
  import etapa2_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_tap_step,
  input  logic       i_win_step,
  output logic [1:0] o_ch,
  output logic [1:0] o_kr,
  output logic [1:0] o_kc,
  output logic [1:0] o_filt,
  output logic [2:0] o_row,
  output logic [2:0] o_col,
  output logic       o_tap_first,
  output logic       o_tap_last,
  output logic       o_win_last
);

  localparam logic [1:0] ChMax   = 2'(N_CH - 1);
  localparam logic [1:0] KMax    = 2'(K - 1);
  localparam logic [1:0] FiltMax = 2'(N_FILT - 1);
  localparam logic [2:0] PixMax  = 3'(OUT_W - 1);

  logic [1:0] r_ch, r_kr, r_kc, r_filt;
  logic [2:0] r_row, r_col;
  logic       w_kc_wrap, w_kr_wrap, w_col_wrap, w_row_wrap;

  assign w_kc_wrap  = (r_kc == KMax);
  assign w_kr_wrap  = w_kc_wrap && (r_kr == KMax);
  assign w_col_wrap = (r_col == PixMax);
  assign w_row_wrap = w_col_wrap && (r_row == PixMax);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ch   <= '0;
      r_kr   <= '0;
      r_kc   <= '0;
      r_filt <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (i_clr) begin
      r_ch   <= '0;
      r_kr   <= '0;
      r_kc   <= '0;
      r_filt <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else begin
      if (i_tap_step) begin
        r_kc <= w_kc_wrap ? 2'd0 : r_kc + 2'd1;
        if (w_kc_wrap) r_kr <= (r_kr == KMax) ? 2'd0 : r_kr + 2'd1;
        if (w_kr_wrap) r_ch <= (r_ch == ChMax) ? 2'd0 : r_ch + 2'd1;
      end
      if (i_win_step) begin
        r_col <= w_col_wrap ? 3'd0 : r_col + 3'd1;
        if (w_col_wrap) r_row <= (r_row == PixMax) ? 3'd0 : r_row + 3'd1;
        if (w_row_wrap) r_filt <= (r_filt == FiltMax) ? 2'd0 : r_filt + 2'd1;
      end
    end
  end

  assign o_ch        = r_ch;
  assign o_kr        = r_kr;
  assign o_kc        = r_kc;
  assign o_filt      = r_filt;
  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_tap_first = (r_ch == 2'd0) && (r_kr == 2'd0) && (r_kc == 2'd0);
  assign o_tap_last  = w_kr_wrap && (r_ch == ChMax);
  assign o_win_last  = w_row_wrap && (r_filt == FiltMax);

endmodule

// File: rtl/etapa2_seq_ctrl.sv
// Stage-2 convolution sequencer: walks the stage-1 map in BRAM, aligns tap info with read data
// and hands one result per output pixel per filter downstream.
module etapa2_seq_ctrl
  import etapa2_pkg::*;
#(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_enab,
  output logic [ADDR_W-1:0] o_read_addr,
  output logic              o_mac_valid,
  output logic              o_mac_first,
  output logic              o_mac_last,
  output logic [1:0]        o_chanel_used,
  output logic [1:0]        o_filter_used,
  output logic [1:0]        o_tap_row,
  output logic [1:0]        o_tap_col,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [2:0]        o_out_row,
  output logic [2:0]        o_out_col,
  output logic              o_busy,
  output logic              o_data_done
);

  state_t r_state, w_state_nxt;

  logic [1:0] w_ch, w_kr, w_kc, w_filt;
  logic [2:0] w_row, w_col;
  logic       w_tap_first, w_tap_last, w_win_last;
  logic       w_clr, w_tap_step, w_win_step, w_issue;
  logic [ADDR_W-1:0] w_addr;

  tap_t               r_pipe [READ_LAT];
  logic [READ_LAT-1:0] r_vld;
  tap_t               w_tap_in, w_tap_out;

  s2_window_counter u_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_clr),
    .i_tap_step (w_tap_step),
    .i_win_step (w_win_step),
    .o_ch       (w_ch),
    .o_kr       (w_kr),
    .o_kc       (w_kc),
    .o_filt     (w_filt),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_tap_first(w_tap_first),
    .o_tap_last (w_tap_last),
    .o_win_last (w_win_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_tap_step  = 1'b0;
    w_win_step  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = StRead;
          w_clr       = 1'b1;
        end
      end
      StRead: begin
        w_tap_step = 1'b1;
        if (w_tap_last) w_state_nxt = StDrain;
      end
      // Wait for the window's final tap to emerge from the BRAM latency pipe.
      StDrain: begin
        if (o_mac_last) w_state_nxt = StEmit;
      end
      StEmit: begin
        if (i_out_ready) begin
          w_win_step  = 1'b1;
          w_state_nxt = w_win_last ? StDone : StRead;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_issue = (r_state == StRead);
  assign w_addr  = ADDR_W'(w_ch) * ADDR_W'(PLANE)
                 + (ADDR_W'(w_row) + ADDR_W'(w_kr)) * ADDR_W'(IMG_W)
                 + ADDR_W'(w_col) + ADDR_W'(w_kc);

  assign w_tap_in = {w_ch, w_kr, w_kc, w_filt, w_tap_first & w_issue, w_tap_last & w_issue};

  // Shift issue-side tap info by READ_LAT so it lines up with BRAM data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_vld[0]  <= w_issue;
      r_pipe[0] <= w_tap_in;
      for (int i = 1; i < READ_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_tap_out     = r_pipe[READ_LAT-1];
  assign o_mac_valid   = r_vld[READ_LAT-1];
  assign o_mac_first   = o_mac_valid & w_tap_out.first;
  assign o_mac_last    = o_mac_valid & w_tap_out.last;
  assign o_chanel_used = w_tap_out.ch;
  assign o_filter_used = w_tap_out.filt;
  assign o_tap_row     = w_tap_out.kr;
  assign o_tap_col     = w_tap_out.kc;

  assign o_enab      = w_issue;
  assign o_read_addr = w_issue ? w_addr : '0;
  assign o_out_valid = (r_state == StEmit);
  assign o_out_row   = w_row;
  assign o_out_col   = w_col;
  assign o_busy      = (r_state != StIdle);
  assign o_data_done = (r_state == StDone);

endmodule

// File: tb/tb_etapa2_seq_ctrl.sv
// Scoreboard bench: two sequencers (READ_LAT 1 and 3) share stimulus; expected streams are
// generated from the loop-order rules on each start and popped by a negedge monitor.
module tb_etapa2_seq_ctrl;

  typedef struct packed {
    logic       enab;
    logic [7:0] addr;
    logic       mv;
    logic       mf;
    logic       ml;
    logic [1:0] ch;
    logic [1:0] filt;
    logic [1:0] kr;
    logic [1:0] kc;
    logic       ov;
    logic [2:0] row;
    logic [2:0] col;
    logic       busy;
    logic       dd;
  } obs_t;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  obs_t obs [2];

  always #5 clk = ~clk;

  etapa2_seq_ctrl #(.READ_LAT(1), .ADDR_W(8)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .o_enab(obs[0].enab), .o_read_addr(obs[0].addr),
    .o_mac_valid(obs[0].mv), .o_mac_first(obs[0].mf), .o_mac_last(obs[0].ml),
    .o_chanel_used(obs[0].ch), .o_filter_used(obs[0].filt),
    .o_tap_row(obs[0].kr), .o_tap_col(obs[0].kc),
    .o_out_valid(obs[0].ov), .i_out_ready(out_ready),
    .o_out_row(obs[0].row), .o_out_col(obs[0].col),
    .o_busy(obs[0].busy), .o_data_done(obs[0].dd)
  );

  etapa2_seq_ctrl #(.READ_LAT(3), .ADDR_W(8)) u_dut3 (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .o_enab(obs[1].enab), .o_read_addr(obs[1].addr),
    .o_mac_valid(obs[1].mv), .o_mac_first(obs[1].mf), .o_mac_last(obs[1].ml),
    .o_chanel_used(obs[1].ch), .o_filter_used(obs[1].filt),
    .o_tap_row(obs[1].kr), .o_tap_col(obs[1].kc),
    .o_out_valid(obs[1].ov), .i_out_ready(out_ready),
    .o_out_row(obs[1].row), .o_out_col(obs[1].col),
    .o_busy(obs[1].busy), .o_data_done(obs[1].dd)
  );

  // Requests from the stimulus process to the monitor (monitor owns all checking state).
  bit req_push = 1'b0, req_chk_rst = 1'b0, req_chk_end = 1'b0;
  int n_timeouts = 0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int q_addr [2][$];
  int q_tap  [2][$];
  int q_res  [2][$];
  logic [3:0] hist [2];
  bit prev_ov [2], acc_valid [2], stall [2], done_prev [2], done_seen [2];
  int prev_key [2], acc_cyc [2], res_cnt [2], done_cnt [2];

  task automatic chk(input string name, input int d, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, got, want, $time);
    end
  endtask

  // Reference stream: filter, out_row, out_col | channel, tap_row, tap_col.
  task automatic push_stream(input int d);
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          q_res[d].push_back((f << 6) | (r << 3) | c);
          for (int ch = 0; ch < 3; ch++)
            for (int kr = 0; kr < 3; kr++)
              for (int kc = 0; kc < 3; kc++) begin
                int first, last;
                first = (ch == 0 && kr == 0 && kc == 0) ? 1 : 0;
                last  = (ch == 2 && kr == 2 && kc == 2) ? 1 : 0;
                q_addr[d].push_back(ch * 64 + (r + kr) * 8 + (c + kc));
                q_tap[d].push_back((ch << 8) | (kr << 6) | (kc << 4) | (f << 2) | (first << 1) | last);
              end
        end
  endtask

  task automatic check_dut(input int d);
    obs_t o;
    int   rl;
    o  = obs[d];
    rl = (d == 0) ? 1 : 3;
    if (o.enab) begin
      if (q_addr[d].size() == 0) chk("addr_unexpected", d, q_addr[d].size(), 1);
      else chk("read_addr", d, int'(o.addr), q_addr[d].pop_front());
    end
    if (o.mv || hist[d][rl-1]) chk("mac_align", d, int'(o.mv), int'(hist[d][rl-1]));
    hist[d] = {hist[d][2:0], o.enab};
    if (o.mv) begin
      if (q_tap[d].size() == 0) chk("tap_unexpected", d, q_tap[d].size(), 1);
      else chk("tap_fields", d, int'({o.ch, o.kr, o.kc, o.filt, o.mf, o.ml}),
               q_tap[d].pop_front());
    end
    if (o.ov) begin
      chk("enab_in_emit", d, int'(o.enab), 0);
      if (prev_ov[d]) chk("emit_stable", d, int'({o.filt, o.row, o.col}), prev_key[d]);
      prev_key[d] = int'({o.filt, o.row, o.col});
      if (!out_ready) stall[d] = 1'b1;
      else begin
        if (q_res[d].size() == 0) chk("result_unexpected", d, q_res[d].size(), 1);
        else chk("result_pixel", d, int'({o.filt, o.row, o.col}), q_res[d].pop_front());
        if (acc_valid[d] && !stall[d]) chk("window_period", d, cyc - acc_cyc[d], 28 + rl);
        acc_cyc[d]   = cyc;
        acc_valid[d] = 1'b1;
        stall[d]     = 1'b0;
        res_cnt[d]++;
      end
    end
    prev_ov[d] = o.ov && !out_ready;
    if (done_prev[d]) chk("busy_after_done", d, int'(o.busy), 0);
    if (o.dd) begin
      chk("busy_at_done", d, int'(o.busy), 1);
      done_cnt[d]++;
      done_seen[d] = 1'b1;
    end
    done_prev[d] = o.dd;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (req_chk_rst) chk("reset_outputs", d, int'(obs[d]), 0);
        q_addr[d].delete();
        q_tap[d].delete();
        q_res[d].delete();
        hist[d]      = '0;
        prev_ov[d]   = 1'b0;
        acc_valid[d] = 1'b0;
        stall[d]     = 1'b0;
        done_prev[d] = 1'b0;
        done_seen[d] = 1'b0;
        res_cnt[d]   = 0;
        done_cnt[d]  = 0;
      end else begin
        if (req_push) push_stream(d);
        if (req_chk_end) begin
          chk("result_count", d, res_cnt[d], 144);
          chk("done_count", d, done_cnt[d], 1);
          chk("leftover", d, q_addr[d].size() + q_tap[d].size() + q_res[d].size(), 0);
          if (d == 0) chk("wait_bound", d, n_timeouts, 0);
          res_cnt[d]   = 0;
          done_cnt[d]  = 0;
          done_seen[d] = 1'b0;
          acc_valid[d] = 1'b0;
        end
        check_dut(d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: stall window 5 and stray start; mode 1: random ready, reset mid filter 2;
  // mode 2: random ready, full pass.
  task automatic run_pass(input int mode);
    int hold    = 0;
    bit stalled = 1'b0;
    bit hit     = 1'b0;
    start    = 1'b1;
    req_push = 1'b1;
    tick();
    start    = 1'b0;
    req_push = 1'b0;
    for (int c = 1; c < 20000; c++) begin
      if (mode == 1 && res_cnt[0] >= 74 && obs[0].enab) begin
        hit = 1'b1;
        break;
      end
      if (mode != 1 && done_seen[0] && done_seen[1]) begin
        hit = 1'b1;
        break;
      end
      start = (mode == 0 && c == 40);
      if (mode == 0) begin
        if (!stalled && res_cnt[0] == 5 && obs[0].ov) begin
          stalled = 1'b1;
          hold    = 10;
        end
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else out_ready = 1'b1;
      end else out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!hit) begin
      n_timeouts++;
      $display("FAIL wait_bound mode %0d: got no completion, expected one within budget", mode);
    end
    if (mode != 1) begin
      req_chk_end = 1'b1;
      tick();
      req_chk_end = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    req_chk_rst = 1'b1;
    tick();
    req_chk_rst = 1'b0;
    rst         = 1'b0;
    tick();
    tick();

    run_pass(0);
    run_pass(1);
    rst         = 1'b1;
    req_chk_rst = 1'b1;
    tick();
    req_chk_rst = 1'b0;
    rst         = 1'b0;
    tick();
    run_pass(2);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
